// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding, ACK polarity and synchronizer depth.
package i2c_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA pad synchronizer with registered SCL edge and START/STOP condition pulses.
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_pad,
  input  logic sda_pad,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_hist;
  logic                   sda_hist;
  logic                   scl_now;
  logic                   sda_now;

  assign scl_now = scl_sync[SYNC_STAGES-1];
  assign sda_now = sda_sync[SYNC_STAGES-1];

  // Idle bus is high, so reset to 1 to avoid phantom edges after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
      sda      <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pad};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pad};
      scl_hist <= scl_now;
      sda_hist <= sda_now;
      scl_rise <= scl_now & ~scl_hist;
      scl_fall <= ~scl_now & scl_hist;
      start    <= scl_now & scl_hist & sda_hist & ~sda_now;
      stop     <= scl_now & scl_hist & ~sda_hist & sda_now;
      sda      <= sda_now;
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with pointer-addressed 8-bit register file and a direct host access port.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h3C,
  parameter int unsigned REG_DEPTH   = 16
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  input  logic [7:0] host_addr,
  input  logic       host_we,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic       i2c_wr_stb,
  output logic [7:0] i2c_wr_addr,
  output logic [7:0] i2c_wr_data,
  output logic       busy
);

  localparam int unsigned AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  logic           scl_rise;
  logic           scl_fall;
  logic           ev_start;
  logic           ev_stop;
  logic           sda_lvl;

  i2c_tgt_state_t state;
  logic [7:0]     regs [REG_DEPTH];
  logic [7:0]     shift;
  logic [7:0]     ptr;
  logic [2:0]     bit_cnt;
  logic           rw;
  logic           ack_on;

  logic           host_in_range;
  logic           ptr_in_range;
  logic [7:0]     rx_byte;
  logic [7:0]     rd_cur;

  i2c_bus_sync u_sync (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .scl_pad  (scl_i),
    .sda_pad  (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (ev_start),
    .stop     (ev_stop),
    .sda      (sda_lvl)
  );

  assign sda_o         = 1'b0;
  assign host_in_range = 32'(host_addr) < REG_DEPTH;
  assign ptr_in_range  = 32'(ptr) < REG_DEPTH;
  assign host_rdata    = host_in_range ? regs[AW'(host_addr)] : 8'hFF;
  assign rd_cur        = ptr_in_range ? regs[AW'(ptr)] : 8'hFF;
  assign rx_byte       = {shift[6:0], sda_lvl};

  // Protocol FSM; the I2C register write follows the host write so it wins a collision.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      shift       <= 8'h00;
      ptr         <= 8'h00;
      bit_cnt     <= 3'd0;
      rw          <= 1'b0;
      ack_on      <= 1'b0;
      sda_t       <= 1'b1;
      busy        <= 1'b0;
      i2c_wr_stb  <= 1'b0;
      i2c_wr_addr <= 8'h00;
      i2c_wr_data <= 8'h00;
      for (int i = 0; i < int'(REG_DEPTH); i++) regs[i] <= 8'h00;
    end else begin
      i2c_wr_stb <= 1'b0;
      if (host_we && host_in_range) regs[AW'(host_addr)] <= host_wdata;

      if (ev_start) begin
        state   <= ST_ADDR;
        bit_cnt <= 3'd0;
        ack_on  <= 1'b0;
        sda_t   <= 1'b1;
      end else if (ev_stop) begin
        state  <= ST_IDLE;
        ack_on <= 1'b0;
        sda_t  <= 1'b1;
        busy   <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (state == ST_ADDR) begin
                  if (rx_byte[7:1] == TARGET_ADDR) begin
                    rw    <= rx_byte[0];
                    busy  <= 1'b1;
                    state <= ST_ADDR_ACK;
                  end else begin
                    state <= ST_WAIT_STOP;
                  end
                end else if (state == ST_PTR) begin
                  ptr   <= rx_byte;
                  state <= ST_PTR_ACK;
                end else begin
                  if (ptr_in_range) regs[AW'(ptr)] <= rx_byte;
                  i2c_wr_stb  <= 1'b1;
                  i2c_wr_addr <= ptr;
                  i2c_wr_data <= rx_byte;
                  ptr         <= ptr + 8'd1;
                  state       <= ST_WDATA_ACK;
                end
              end
            end
          end

          // First SCL fall starts the ACK drive, the second ends it and hands off.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_t  <= I2C_ACK;
                ack_on <= 1'b1;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= 3'd0;
                if (state == ST_ADDR_ACK && rw) begin
                  state <= ST_RDATA;
                  sda_t <= rd_cur[7];
                  shift <= {rd_cur[6:0], 1'b1};
                end else begin
                  sda_t <= 1'b1;
                  state <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                end
              end
            end
          end

          ST_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_t   <= 1'b1;
                bit_cnt <= 3'd0;
                ack_on  <= 1'b0;
                state   <= ST_RDATA_ACK;
              end else begin
                sda_t   <= shift[7];
                shift   <= {shift[6:0], 1'b1};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end

          ST_RDATA_ACK: begin
            if (scl_rise) begin
              if (sda_lvl == I2C_ACK) begin
                ptr    <= ptr + 8'd1;
                ack_on <= 1'b1;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end else if (scl_fall && ack_on) begin
              ack_on  <= 1'b0;
              bit_cnt <= 3'd0;
              sda_t   <= rd_cur[7];
              shift   <= {rd_cur[6:0], 1'b1};
              state   <= ST_RDATA;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed plus randomized bench for i2c_target_regs, checked against a register/pointer model.
module tb_i2c_target_regs;

  localparam int Q = 6;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic       scl_m;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_o;
  logic       sda_t;
  logic [7:0] host_addr;
  logic       host_we;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       i2c_wr_stb;
  logic [7:0] i2c_wr_addr;
  logic [7:0] i2c_wr_data;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mregs [16];
  int          mptr;
  logic [7:0]  tx [4];
  logic [15:0] stb_q [$];
  bit          drove;

  always #5 wb_clk_i = ~wb_clk_i;

  assign sda_bus = sda_m & (sda_t | sda_o);

  i2c_target_regs dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .scl_i       (scl_m),
    .sda_i       (sda_bus),
    .sda_o       (sda_o),
    .sda_t       (sda_t),
    .host_addr   (host_addr),
    .host_we     (host_we),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .i2c_wr_stb  (i2c_wr_stb),
    .i2c_wr_addr (i2c_wr_addr),
    .i2c_wr_data (i2c_wr_data),
    .busy        (busy)
  );

  always @(negedge wb_clk_i) begin
    if (i2c_wr_stb) stb_q.push_back({i2c_wr_addr, i2c_wr_data});
    if (!sda_t) drove = 1'b1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge wb_clk_i);
  endtask

  function automatic logic [7:0] mread(input int p);
    return (p < 16) ? mregs[p] : 8'hFF;
  endfunction

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq(); wq();
  endtask

  task automatic i2c_wbyte(input logic [7:0] b, output logic ack, input bit collide);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wq();
      scl_m = 1'b1;
      if (collide && i == 0) begin
        repeat (3) @(negedge wb_clk_i);
        host_addr = 8'd2; host_wdata = 8'h11; host_we = 1'b1;
        @(negedge wb_clk_i);
        chk("collide_stb", i2c_wr_stb, 1'b1);
        chk("collide_rdata", host_rdata, 8'h22);
        host_we = 1'b0;
        repeat (2*Q-4) @(negedge wb_clk_i);
      end else begin
        wq(); wq();
      end
      scl_m = 1'b0; wq();
    end
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    ack = sda_bus; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_rbyte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      wq();
      scl_m = 1'b1; wq();
      b[i] = sda_bus; wq();
      scl_m = 1'b0;
    end
    repeat (2) @(negedge wb_clk_i);
    sda_m = mack; wq();
    scl_m = 1'b1; wq(); wq();
    scl_m = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    sda_m = 1'b1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge wb_clk_i);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    @(negedge wb_clk_i);
    host_we = 1'b0;
    if (a < 16) mregs[a] = d;
  endtask

  task automatic wr_txn(input logic [7:0] p, input int n);
    logic ack;
    stb_q.delete();
    i2c_start();
    i2c_wbyte(8'h78, ack, 1'b0);
    chk("wr_addr_ack", ack, 1'b0);
    chk("wr_busy", busy, 1'b1);
    i2c_wbyte(p, ack, 1'b0);
    chk("wr_ptr_ack", ack, 1'b0);
    mptr = p;
    for (int k = 0; k < n; k++) begin
      i2c_wbyte(tx[k], ack, 1'b0);
      chk("wr_data_ack", ack, 1'b0);
      if (mptr < 16) mregs[mptr] = tx[k];
      mptr = (mptr + 1) % 256;
    end
    i2c_stop();
    chk("wr_busy_stop", busy, 1'b0);
    chk("wr_stb_count", stb_q.size(), n);
    for (int k = 0; k < n && k < stb_q.size(); k++)
      chk("wr_stb_entry", stb_q[k], {8'((int'(p) + k) % 256), tx[k]});
  endtask

  task automatic rd_txn(input bit setp, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] b;
    i2c_start();
    if (setp) begin
      i2c_wbyte(8'h78, ack, 1'b0);
      chk("rd_waddr_ack", ack, 1'b0);
      i2c_wbyte(p, ack, 1'b0);
      chk("rd_ptr_ack", ack, 1'b0);
      mptr = p;
      i2c_start();
    end
    i2c_wbyte(8'h79, ack, 1'b0);
    chk("rd_addr_ack", ack, 1'b0);
    chk("rd_busy", busy, 1'b1);
    for (int k = 0; k < n; k++) begin
      i2c_rbyte((k == n-1) ? 1'b1 : 1'b0, b);
      chk("rd_data", b, mread(mptr));
      if (k != n-1) mptr = (mptr + 1) % 256;
    end
    i2c_stop();
    chk("rd_busy_stop", busy, 1'b0);
  endtask

  task automatic compare_all();
    for (int i = 0; i < 16; i++) begin
      @(negedge wb_clk_i);
      host_addr = 8'(i);
      #1 chk("host_reg", host_rdata, mregs[i]);
    end
    @(negedge wb_clk_i);
    host_addr = 8'd16;
    #1 chk("host_oor16", host_rdata, 8'hFF);
    host_addr = 8'hFF;
    #1 chk("host_oorff", host_rdata, 8'hFF);
  endtask

  initial begin
    logic ack;
    logic [7:0] b;
    int op;
    wb_rst_i = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    host_addr = 8'h00; host_we = 1'b0; host_wdata = 8'h00;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 0;
    repeat (4) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    chk("rst_sda_t", sda_t, 1'b1);
    chk("rst_sda_o", sda_o, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stb", i2c_wr_stb, 1'b0);
    chk("rst_wr_addr", i2c_wr_addr, 8'h00);
    chk("rst_wr_data", i2c_wr_data, 8'h00);
    chk("rst_rdata", host_rdata, 8'h00);

    // Write burst, then current-address read proves the pointer landed at 7.
    tx[0] = 8'hA5; tx[1] = 8'h5A;
    wr_txn(8'h05, 2);
    chk("burst_ptr", mptr, 7);
    host_write(8'd7, 8'hC7);
    rd_txn(1'b0, 8'h00, 1);
    compare_all();

    rd_txn(1'b1, 8'h05, 2);

    // Address mismatch: never drives SDA, no strobes.
    drove = 1'b0;
    stb_q.delete();
    i2c_start();
    i2c_wbyte(8'h7A, ack, 1'b0);
    chk("mis_addr_nack", ack, 1'b1);
    chk("mis_busy", busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      i2c_wbyte(8'(8'h11 * (k + 1)), ack, 1'b0);
      chk("mis_data_nack", ack, 1'b1);
    end
    i2c_stop();
    chk("mis_drove", drove, 1'b0);
    chk("mis_stb", stb_q.size(), 0);
    compare_all();

    // Out-of-range pointer: ACKed, dropped, reads 0xFF.
    tx[0] = 8'h33;
    wr_txn(8'h1F, 1);
    compare_all();
    rd_txn(1'b1, 8'h1F, 1);

    // Pointer wrap 0xFF -> 0x00.
    tx[0] = 8'h44; tx[1] = 8'h99;
    wr_txn(8'hFF, 2);
    chk("wrap_ptr", mptr, 1);
    compare_all();

    // Host write collides with I2C write to reg[2]; I2C wins.
    i2c_start();
    i2c_wbyte(8'h78, ack, 1'b0);
    i2c_wbyte(8'h02, ack, 1'b0);
    i2c_wbyte(8'h22, ack, 1'b1);
    chk("collide_ack", ack, 1'b0);
    i2c_stop();
    mregs[2] = 8'h22; mptr = 3;
    compare_all();

    // Reset during a read byte while SDA is driven low.
    i2c_start();
    i2c_wbyte(8'h78, ack, 1'b0);
    i2c_wbyte(8'h05, ack, 1'b0);
    i2c_start();
    i2c_wbyte(8'h79, ack, 1'b0);
    for (int i = 7; i >= 5; i--) begin
      wq();
      scl_m = 1'b1; wq(); b[i] = sda_bus; wq();
      scl_m = 1'b0;
    end
    wq();
    chk("mid_read_bits", b[7:5], 3'b101);
    chk("mid_read_drive", sda_t, 1'b0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    chk("mid_rst_release", sda_t, 1'b1);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mptr = 0;
    i2c_stop();
    compare_all();
    tx[0] = 8'h6E; tx[1] = 8'h81;
    wr_txn(8'h03, 2);
    rd_txn(1'b1, 8'h03, 2);

    // Randomized mix of I2C writes, reads and host writes.
    for (int it = 0; it < 14; it++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        for (int k = 0; k < 4; k++) tx[k] = 8'($urandom);
        wr_txn(8'($urandom_range(0, 20)), $urandom_range(1, 3));
      end else if (op == 1) begin
        rd_txn(1'b1, 8'($urandom_range(0, 20)), $urandom_range(1, 3));
      end else begin
        host_write(8'($urandom_range(0, 20)), 8'($urandom));
      end
    end
    compare_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
